// File: rtl/vend_dispense_scheduler.sv
// Shared dispense-motor scheduler: queues paid vend requests and runs one slot at a time,
// confirming each item on the drop sensor with a timed retry and a latched jam fault.
module vend_dispense_scheduler #(
  parameter int NUM_SLOTS      = 4,
  parameter int QDEPTH         = 4,
  parameter int MOTOR_CYCLES   = 8,
  parameter int TIMEOUT_CYCLES = 32,
  parameter int MAX_RETRY      = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        req_valid,
  input  logic [NUM_SLOTS-1:0]        req_slot,
  output logic                        req_ready,
  input  logic                        drop_sensor,
  input  logic                        fault_clear,
  output logic                        motor_control,
  output logic [NUM_SLOTS-1:0]        motor_slot,
  output logic                        dispensed_pulse,
  output logic                        fault,
  output logic [$clog2(QDEPTH+1)-1:0] queue_count,
  output logic [3:0]                  status_leds
);
  localparam int CW   = $clog2(QDEPTH+1);
  localparam int AW   = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int PMAX = (MOTOR_CYCLES > TIMEOUT_CYCLES) ? MOTOR_CYCLES : TIMEOUT_CYCLES;
  localparam int PW   = $clog2(PMAX+1);
  localparam int RW   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY+1) : 1;

  typedef enum logic [2:0] {IDLE, RUN, WAIT_DROP, DONE, FAULT} state_t;

  state_t               state, state_nx;
  logic [PW-1:0]        phase, phase_nx;
  logic [RW-1:0]        retry, retry_nx;
  logic [NUM_SLOTS-1:0] slot, slot_nx;
  logic                 busy;

  logic [NUM_SLOTS-1:0] mem [QDEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count;
  logic                 full, empty, push, pop;

  assign full      = (count == CW'(QDEPTH));
  assign empty     = (count == '0);
  assign req_ready = !full && !fault;
  assign push      = req_valid && req_ready && $onehot(req_slot);
  assign pop       = (state == IDLE) && !empty;

  // Pointers rely on QDEPTH being a power of two to wrap for free.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= req_slot;
  end

  always_comb begin
    state_nx = state;
    retry_nx = retry;
    slot_nx  = slot;
    phase_nx = phase;
    case (state)
      IDLE: if (!empty) begin
        state_nx = RUN;
        slot_nx  = mem[rd_ptr];
        retry_nx = '0;
      end
      RUN: begin
        if (drop_sensor)                          state_nx = DONE;
        else if (phase == PW'(MOTOR_CYCLES - 1))  state_nx = WAIT_DROP;
      end
      WAIT_DROP: begin
        if (drop_sensor) state_nx = DONE;
        else if (phase == PW'(TIMEOUT_CYCLES - 1)) begin
          if (retry < RW'(MAX_RETRY)) begin
            retry_nx = retry + RW'(1);
            state_nx = RUN;
          end else begin
            state_nx = FAULT;
          end
        end
      end
      DONE:  state_nx = IDLE;
      FAULT: if (fault_clear) begin
        state_nx = IDLE;
        slot_nx  = '0;
      end
      default: state_nx = IDLE;
    endcase
    // Shared phase timer: restarts on any state change (retry included), saturates otherwise.
    if (state_nx != state)  phase_nx = '0;
    else if (phase != '1)   phase_nx = phase + PW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      phase           <= '0;
      retry           <= '0;
      slot            <= '0;
      motor_control   <= 1'b0;
      motor_slot      <= '0;
      dispensed_pulse <= 1'b0;
      fault           <= 1'b0;
      busy            <= 1'b0;
    end else begin
      state           <= state_nx;
      phase           <= phase_nx;
      retry           <= retry_nx;
      slot            <= slot_nx;
      motor_control   <= (state_nx == RUN);
      motor_slot      <= (state_nx == RUN) ? slot_nx : '0;
      dispensed_pulse <= (state_nx == DONE);
      fault           <= (state_nx == FAULT);
      busy            <= (state_nx == RUN) || (state_nx == WAIT_DROP) || (state_nx == DONE);
    end
  end

  assign queue_count = count;
  assign status_leds = {fault, busy, full, empty};
endmodule

// File: tb/tb_vend_dispense_scheduler.sv
// Bench for vend_dispense_scheduler: vector table, directed corner sequences, and
// random traffic against an attempt-timeline reference model.
module tb_vend_dispense_scheduler;
  localparam int NS = 4, QD = 4, MC = 8, TC = 32, MR = 1;

  logic          clk = 1'b0, reset = 1'b0;
  logic          req_valid = 1'b0, drop_sensor = 1'b0, fault_clear = 1'b0;
  logic [NS-1:0] req_slot = '0;
  logic          req_ready, motor_control, dispensed_pulse, fault;
  logic [NS-1:0] motor_slot;
  logic [2:0]    queue_count;
  logic [3:0]    status_leds;

  int passed = 0, total = 0;

  always #5 clk = ~clk;

  vend_dispense_scheduler #(.NUM_SLOTS(NS), .QDEPTH(QD), .MOTOR_CYCLES(MC),
                            .TIMEOUT_CYCLES(TC), .MAX_RETRY(MR)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_slot(req_slot),
    .req_ready(req_ready), .drop_sensor(drop_sensor), .fault_clear(fault_clear),
    .motor_control(motor_control), .motor_slot(motor_slot),
    .dispensed_pulse(dispensed_pulse), .fault(fault), .queue_count(queue_count),
    .status_leds(status_leds));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: queue of slots plus the item in service described by its attempt
  // number and elapsed cycles within the attempt (motor for MC cycles, then TC of waiting).
  logic [NS-1:0] mq[$];
  logic [NS-1:0] m_cur;
  bit            m_srv, m_pulse, m_flt;
  int            m_t, m_att;

  function automatic void model_reset();
    mq.delete();
    m_cur = '0; m_srv = 0; m_pulse = 0; m_flt = 0; m_t = 0; m_att = 0;
  endfunction

  function automatic void model_edge(input bit v, input logic [NS-1:0] s, input bit d, input bit c);
    bit rdy, psh;
    rdy = (mq.size() < QD) && !m_flt;
    psh = v && rdy && $onehot(s);
    if (m_pulse) m_pulse = 0;
    else if (m_srv) begin
      if (d) begin m_srv = 0; m_pulse = 1; end
      else if (m_t == MC + TC - 1) begin
        if (m_att < MR) begin m_att++; m_t = 0; end
        else begin m_srv = 0; m_flt = 1; end
      end else m_t++;
    end else if (m_flt) begin
      if (c) m_flt = 0;
    end else if (mq.size() > 0) begin
      m_cur = mq.pop_front(); m_srv = 1; m_t = 0; m_att = 0;
    end
    if (psh) mq.push_back(s);
  endfunction

  function automatic logic [14:0] model_out();
    bit mot;
    bit rdy;
    mot = m_srv && (m_t < MC);
    rdy = (mq.size() < QD) && !m_flt;
    return {rdy, mot, (mot ? m_cur : 4'b0000), m_pulse, m_flt, 3'(mq.size()),
            m_flt, (m_srv || m_pulse), (mq.size() == QD), (mq.size() == 0)};
  endfunction

  function automatic logic [14:0] dut_out();
    return {req_ready, motor_control, motor_slot, dispensed_pulse, fault, queue_count, status_leds};
  endfunction

  task automatic drive(input logic v, input logic [NS-1:0] s, input logic d, input logic c);
    req_valid = v; req_slot = s; drop_sensor = d; fault_clear = c;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    tick(); tick();
    reset = 1'b1;
    model_reset();
  endtask

  // Waits (bounded) for the motor, checks its slot, then confirms the drop.
  task automatic serve(input string nm, input logic [NS-1:0] exp);
    int n;
    n = 0;
    while (!motor_control && n < 200) begin tick(); n++; end
    chk({nm, "_slot"}, motor_slot, exp);
    drive(1'b0, '0, 1'b1, 1'b0); tick();
    chk({nm, "_pulse"}, dispensed_pulse, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b0); tick();
    chk({nm, "_pulse_end"}, dispensed_pulse, 1'b0);
  endtask

  typedef struct {
    logic          v;
    logic [NS-1:0] s;
    logic          d, c;
    logic          e_ready, e_motor;
    logic [NS-1:0] e_mslot;
    logic          e_pulse;
    logic [2:0]    e_cnt;
    logic [3:0]    e_leds;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic [3:0] s, input logic d, input logic c,
                              input logic r, input logic m, input logic [3:0] ms, input logic p,
                              input logic [2:0] cnt, input logic [3:0] leds);
    vec_t x;
    x.v = v; x.s = s; x.d = d; x.c = c; x.e_ready = r; x.e_motor = m;
    x.e_mslot = ms; x.e_pulse = p; x.e_cnt = cnt; x.e_leds = leds;
    return x;
  endfunction

  vec_t          tbl[12];
  logic [NS-1:0] seq3[6];
  logic [2:0]    cnt3[5];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int on, bursts, first_fault;
    bit prev, pulse_seen, motor_seen;
    logic [3:0] rs;

    // Reset state before any clock edge
    #2;
    chk("rst_motor", motor_control, 1'b0);
    chk("rst_mslot", motor_slot, 4'b0000);
    chk("rst_pulse", dispensed_pulse, 1'b0);
    chk("rst_fault", fault, 1'b0);
    chk("rst_count", queue_count, 3'd0);
    chk("rst_leds", status_leds, 4'b0001);
    chk("rst_ready", req_ready, 1'b1);
    @(negedge clk);
    reset = 1'b1;

    // Vectors: bad one-hot ignored, single item with drop on the 3rd motor cycle,
    // drop in idle and fault_clear outside fault ignored.
    tbl[0]  = mk(1, 4'b0011, 0, 0, 1, 0, 4'b0000, 0, 3'd0, 4'b0001);
    tbl[1]  = mk(0, 4'b0000, 0, 0, 1, 0, 4'b0000, 0, 3'd0, 4'b0001);
    tbl[2]  = mk(1, 4'b0000, 0, 0, 1, 0, 4'b0000, 0, 3'd0, 4'b0001);
    tbl[3]  = mk(1, 4'b0001, 0, 0, 1, 0, 4'b0000, 0, 3'd1, 4'b0000);
    tbl[4]  = mk(0, 4'b0000, 0, 0, 1, 1, 4'b0001, 0, 3'd0, 4'b0101);
    tbl[5]  = mk(0, 4'b0000, 0, 0, 1, 1, 4'b0001, 0, 3'd0, 4'b0101);
    tbl[6]  = mk(0, 4'b0000, 0, 0, 1, 1, 4'b0001, 0, 3'd0, 4'b0101);
    tbl[7]  = mk(0, 4'b0000, 1, 0, 1, 0, 4'b0000, 1, 3'd0, 4'b0101);
    tbl[8]  = mk(0, 4'b0000, 0, 0, 1, 0, 4'b0000, 0, 3'd0, 4'b0001);
    tbl[9]  = mk(0, 4'b0000, 1, 0, 1, 0, 4'b0000, 0, 3'd0, 4'b0001);
    tbl[10] = mk(0, 4'b0000, 0, 1, 1, 0, 4'b0000, 0, 3'd0, 4'b0001);
    tbl[11] = mk(1, 4'b1100, 0, 0, 1, 0, 4'b0000, 0, 3'd0, 4'b0001);
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].v, tbl[i].s, tbl[i].d, tbl[i].c);
      tick();
      chk($sformatf("vec%0d", i),
          {req_ready, motor_control, motor_slot, dispensed_pulse, queue_count, status_leds},
          {tbl[i].e_ready, tbl[i].e_motor, tbl[i].e_mslot, tbl[i].e_pulse, tbl[i].e_cnt, tbl[i].e_leds});
    end

    // Six back-to-back requests: one in service, four queued, sixth refused
    do_reset();
    seq3 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    cnt3 = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4};
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, seq3[i], 1'b0, 1'b0);
      tick();
      chk($sformatf("q_cnt%0d", i), queue_count, cnt3[i]);
    end
    chk("q_full_leds", status_leds, 4'b0110);
    chk("q_ready_full", req_ready, 1'b0);
    drive(1'b1, seq3[5], 1'b0, 1'b0);
    tick();
    chk("q_sixth_refused", queue_count, 3'd4);
    drive(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) serve($sformatf("q_item%0d", i), seq3[i]);
    chk("q_drained_cnt", queue_count, 3'd0);
    chk("q_drained_leds", status_leds, 4'b0001);

    // No drop: two bursts with timeouts, then fault; refused push; fault_clear resumes queue
    do_reset();
    drive(1'b1, 4'b0001, 1'b0, 1'b0); tick();
    drive(1'b1, 4'b0010, 1'b0, 1'b0); tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    prev = motor_control; on = motor_control ? 1 : 0; bursts = on; first_fault = -1;
    for (int i = 2; i <= 90; i++) begin
      tick();
      if (motor_control && !prev) bursts++;
      if (motor_control) on++;
      prev = motor_control;
      if (fault && first_fault < 0) first_fault = i;
    end
    chk("jam_on_cycles", on, 16);
    chk("jam_bursts", bursts, 2);
    chk("jam_fault_edge", first_fault, 81);
    chk("jam_leds", status_leds, 4'b1000);
    chk("jam_ready", req_ready, 1'b0);
    drive(1'b1, 4'b0100, 1'b0, 1'b0); tick();
    chk("jam_refused_cnt", queue_count, 3'd1);
    drive(1'b0, '0, 1'b1, 1'b0); tick();
    chk("jam_drop_ignored", {fault, dispensed_pulse, motor_control}, 3'b100);
    drive(1'b0, '0, 1'b0, 1'b1); tick();
    chk("jam_cleared", fault, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0); tick();
    chk("jam_next_item", {motor_control, motor_slot}, {1'b1, 4'b0010});
    chk("jam_next_cnt", queue_count, 3'd0);

    // Asynchronous reset mid-RUN with two entries queued
    do_reset();
    drive(1'b1, 4'b0001, 1'b0, 1'b0); tick();
    drive(1'b1, 4'b0010, 1'b0, 1'b0); tick();
    drive(1'b1, 4'b0100, 1'b0, 1'b0); tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("arst_pre_motor", motor_control, 1'b1);
    chk("arst_pre_cnt", queue_count, 3'd2);
    #2 reset = 1'b0;
    #1;
    chk("arst_motor", motor_control, 1'b0);
    chk("arst_mslot", motor_slot, 4'b0000);
    chk("arst_cnt", queue_count, 3'd0);
    chk("arst_leds", status_leds, 4'b0001);
    @(negedge clk);
    reset = 1'b1;
    pulse_seen = 0; motor_seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      pulse_seen |= dispensed_pulse;
      motor_seen |= motor_control;
    end
    chk("arst_no_pulse", pulse_seen, 1'b0);
    chk("arst_no_motor", motor_seen, 1'b0);

    // Random traffic against the reference model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
        chk($sformatf("rnd_reset%0d", i), dut_out(), model_out());
      end
      rs = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : (4'b0001 << $urandom_range(0, 3));
      drive(($urandom_range(0, 2) == 0), rs, ($urandom_range(0, 29) == 0),
            ($urandom_range(0, 7) == 0));
      model_edge(req_valid, req_slot, drop_sensor, fault_clear);
      tick();
      chk($sformatf("rnd%0d", i), dut_out(), model_out());
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
